// File: rtl/router_pkg.sv
// Shared router constants and types, reused by the input stage, allocator and node top.
package router_pkg;

  localparam int unsigned FLIT_W   = 11;
  localparam int unsigned TAIL_BIT = 10;
  localparam int unsigned HOP_W    = 4;
  localparam int unsigned HOP_LSB  = 6;
  localparam int unsigned CNT_W    = 16;

  typedef logic [FLIT_W-1:0] flit_t;
  typedef logic [HOP_W-1:0]  hop_t;

  // Output allocator selection: keep going, or divert to Braindrop.
  typedef enum logic {
    DEST_FWD   = 1'b0,
    DEST_LOCAL = 1'b1
  } dest_t;

  // Packet framing state: next loaded flit is a header, or part of a packet body.
  typedef enum logic {
    ST_HEADER = 1'b0,
    ST_BODY   = 1'b1
  } pkt_state_t;

  function automatic hop_t hop_of(input flit_t flit);
    return flit[HOP_LSB +: HOP_W];
  endfunction

endpackage

// File: rtl/input_router_if.sv
// Input FIFO pop side plus the two allocator req/ready channels of one input port.
interface input_router_if #(
  parameter int unsigned FLIT_W = router_pkg::FLIT_W
);

  logic              in_empty;
  logic [FLIT_W-1:0] in_data;
  logic              in_rd;
  logic              req_0;
  logic              req_1;
  logic [FLIT_W-1:0] data_out_0;
  logic [FLIT_W-1:0] data_out_1;
  logic              ready_0;
  logic              ready_1;

  // Router stage side.
  modport master (
    input  in_empty, in_data, ready_0, ready_1,
    output in_rd, req_0, req_1, data_out_0, data_out_1
  );

  // FIFO / allocator side.
  modport slave (
    output in_empty, in_data, ready_0, ready_1,
    input  in_rd, req_0, req_1, data_out_0, data_out_1
  );

endinterface

// File: rtl/input_router.sv
// Input-side router stage: pops flits, decodes the header hop count and steers
// whole packets (wormhole) to the forward or Braindrop allocator.
module input_router #(
  parameter int unsigned FLIT_W  = router_pkg::FLIT_W,
  parameter int unsigned HOP_W   = router_pkg::HOP_W,
  parameter int unsigned HOP_LSB = router_pkg::HOP_LSB,
  parameter int unsigned CNT_W   = router_pkg::CNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input_router_if.master       bus,
  output logic [CNT_W-1:0]     pkt_cnt_0,
  output logic [CNT_W-1:0]     pkt_cnt_1
);

  import router_pkg::*;

  logic [FLIT_W-1:0] r_hold;
  logic              r_hold_valid;
  dest_t             r_dest;
  pkt_state_t        r_state;
  pkt_state_t        w_state_nxt;
  logic [FLIT_W-1:0] w_load_flit;
  dest_t             w_load_dest;
  logic [HOP_W-1:0]  w_hop;
  logic              w_req_0;
  logic              w_req_1;
  logic              w_xfer;
  logic              w_load;
  logic [CNT_W-1:0]  r_cnt_0;
  logic [CNT_W-1:0]  r_cnt_1;

  assign w_req_0 = r_hold_valid & (r_dest == DEST_FWD);
  assign w_req_1 = r_hold_valid & (r_dest == DEST_LOCAL);
  assign w_xfer  = (w_req_0 & bus.ready_0) | (w_req_1 & bus.ready_1);
  // Reset gating keeps the FIFO untouched while the holding register is being cleared.
  assign w_load  = ~reset & ~bus.in_empty & (~r_hold_valid | w_xfer);
  assign w_hop   = bus.in_data[HOP_LSB +: HOP_W];

  assign bus.in_rd      = w_load;
  assign bus.req_0      = w_req_0;
  assign bus.req_1      = w_req_1;
  assign bus.data_out_0 = w_req_0 ? r_hold : '0;
  assign bus.data_out_1 = w_req_1 ? r_hold : '0;
  assign pkt_cnt_0      = r_cnt_0;
  assign pkt_cnt_1      = r_cnt_1;

  // Header decode / hop rewrite of the incoming flit and next framing state.
  always_comb begin
    w_state_nxt = r_state;
    w_load_flit = bus.in_data;
    w_load_dest = r_dest;
    if (w_load) begin
      if (r_state == ST_HEADER) begin
        if (w_hop == '0) begin
          w_load_dest = DEST_LOCAL;
        end else begin
          w_load_dest = DEST_FWD;
          w_load_flit[HOP_LSB +: HOP_W] = w_hop - HOP_W'(1);
        end
      end
      w_state_nxt = bus.in_data[FLIT_W-1] ? ST_HEADER : ST_BODY;
    end
  end

  // Framing state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_HEADER;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Holding register: load on pop, otherwise release on transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_dest       <= DEST_FWD;
    end else if (w_load) begin
      r_hold       <= w_load_flit;
      r_hold_valid <= 1'b1;
      r_dest       <= w_load_dest;
    end else if (w_xfer) begin
      r_hold_valid <= 1'b0;
    end
  end

  // Per-output count of delivered tail flits, wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt_0 <= '0;
      r_cnt_1 <= '0;
    end else begin
      if (w_req_0 & bus.ready_0 & r_hold[FLIT_W-1]) r_cnt_0 <= r_cnt_0 + CNT_W'(1);
      if (w_req_1 & bus.ready_1 & r_hold[FLIT_W-1]) r_cnt_1 <= r_cnt_1 + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_input_router.sv
// Bench for input_router: packet-level model with a one-entry expected-output
// queue, checked every cycle, plus directed literal expectations.
module tb_input_router;

  import router_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pkt_cnt_0;
  logic [15:0] pkt_cnt_1;

  input_router_if #(.FLIT_W(11)) bus ();

  input_router #(
    .FLIT_W (11),
    .HOP_W  (4),
    .HOP_LSB(6),
    .CNT_W  (16)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .pkt_cnt_0(pkt_cnt_0),
    .pkt_cnt_1(pkt_cnt_1)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Source FIFO contents; rd_idx is the show-ahead head.
  logic [10:0] src_q[$];
  int unsigned rd_idx = 0;
  bit          pop_pending = 1'b0;

  // Model: flits the router still owes downstream, with their destination.
  typedef struct packed {
    logic        dest;
    logic [10:0] flit;
  } ent_t;
  ent_t        m_q[$];
  bit          m_hdr = 1'b1;
  bit          m_dest = 1'b0;
  logic [15:0] m_cnt0 = '0;
  logic [15:0] m_cnt1 = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drv_step();
    if (pop_pending) rd_idx++;
    if (rd_idx < src_q.size()) begin
      bus.in_empty = 1'b0;
      bus.in_data  = src_q[rd_idx];
    end else begin
      bus.in_empty = 1'b1;
      bus.in_data  = '0;
    end
  endtask

  task automatic cmp_step();
    bit          r0e, r1e, xfer, exp_rd;
    logic [10:0] d, f;
    logic [3:0]  hop;
    if (reset) begin
      chk("in_rd_during_reset", {31'b0, bus.in_rd}, 0);
      m_q.delete();
      m_hdr  = 1'b1;
      m_dest = 1'b0;
      m_cnt0 = '0;
      m_cnt1 = '0;
    end else begin
      r0e = (m_q.size() != 0) && (m_q[0].dest == 1'b0);
      r1e = (m_q.size() != 0) && (m_q[0].dest == 1'b1);
      d   = (m_q.size() != 0) ? m_q[0].flit : 11'h000;
      chk("req_0", {31'b0, bus.req_0}, {31'b0, r0e});
      chk("req_1", {31'b0, bus.req_1}, {31'b0, r1e});
      chk("data_out_0", {21'b0, bus.data_out_0}, r0e ? {21'b0, d} : 32'h0);
      chk("data_out_1", {21'b0, bus.data_out_1}, r1e ? {21'b0, d} : 32'h0);
      chk("pkt_cnt_0", {16'b0, pkt_cnt_0}, {16'b0, m_cnt0});
      chk("pkt_cnt_1", {16'b0, pkt_cnt_1}, {16'b0, m_cnt1});
      xfer   = (r0e && bus.ready_0) || (r1e && bus.ready_1);
      exp_rd = !bus.in_empty && ((m_q.size() == 0) || xfer);
      chk("in_rd", {31'b0, bus.in_rd}, {31'b0, exp_rd});
      if (xfer) begin
        if (d[10]) begin
          if (r0e) m_cnt0 = m_cnt0 + 16'd1;
          else     m_cnt1 = m_cnt1 + 16'd1;
        end
        void'(m_q.pop_front());
      end
      if (exp_rd) begin
        f = bus.in_data;
        if (m_hdr) begin
          hop = f[9:6];
          if (hop == 4'd0) begin
            m_dest = 1'b1;
          end else begin
            m_dest  = 1'b0;
            f[9:6]  = hop - 4'd1;
          end
        end
        m_q.push_back({m_dest, f});
        m_hdr = bus.in_data[10];
      end
    end
    pop_pending = bus.in_rd;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [10:0] f);
    src_q.push_back(f);
  endtask

  // Waits for a handshake on the given output and checks the flit carried by it.
  task automatic expect_out(input bit port, input logic [10:0] val, input string name,
                            output int waits);
    bit hit;
    hit   = 1'b0;
    waits = 0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      waits++;
      hit = port ? (bus.req_1 === 1'b1 && bus.ready_1 === 1'b1)
                 : (bus.req_0 === 1'b1 && bus.ready_0 === 1'b1);
    end
    chk({name, "_handshake"}, {31'b0, hit}, 1);
    chk(name, {21'b0, (port ? bus.data_out_1 : bus.data_out_0)}, {21'b0, val});
  endtask

  initial begin
    int w;
    reset        = 1'b1;
    bus.ready_0  = 1'b0;
    bus.ready_1  = 1'b0;
    bus.in_empty = 1'b1;
    bus.in_data  = '0;

    fork
      forever begin @(negedge clk); cmp_step(); end
      forever begin @(posedge clk); #1; drv_step(); end
      begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset state
    cyc(3);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_req_0", {31'b0, bus.req_0}, 0);
    chk("rst_req_1", {31'b0, bus.req_1}, 0);
    chk("rst_data_out_0", {21'b0, bus.data_out_0}, 0);
    chk("rst_data_out_1", {21'b0, bus.data_out_1}, 0);
    chk("rst_pkt_cnt_0", {16'b0, pkt_cnt_0}, 0);
    chk("rst_pkt_cnt_1", {16'b0, pkt_cnt_1}, 0);
    cyc(1);

    // Three-flit forward packet, hop 3 -> 2
    bus.ready_0 = 1'b1;
    push(11'h0C5); push(11'h00A); push(11'h40B);
    expect_out(1'b0, 11'h085, "fwd_header", w);
    expect_out(1'b0, 11'h00A, "fwd_body", w);
    chk("fwd_body_gap", w, 1);
    expect_out(1'b0, 11'h40B, "fwd_tail", w);
    chk("fwd_tail_gap", w, 1);
    cyc(2);
    chk("fwd_pkt_cnt_0", {16'b0, pkt_cnt_0}, 1);
    chk("fwd_pkt_cnt_1", {16'b0, pkt_cnt_1}, 0);

    // Single-flit local packet, hop 0
    bus.ready_1 = 1'b1;
    push(11'h42A);
    expect_out(1'b1, 11'h42A, "local_single", w);
    chk("local_idle_out0", {21'b0, bus.data_out_0}, 0);
    cyc(2);
    chk("local_pkt_cnt_1", {16'b0, pkt_cnt_1}, 1);

    // Back-pressure mid-packet, hop 4 -> 3
    bus.ready_0 = 1'b0;
    push(11'h100); push(11'h011); push(11'h012); push(11'h013); push(11'h414);
    cyc(5);
    @(negedge clk);
    chk("bp_in_rd_low", {31'b0, bus.in_rd}, 0);
    chk("bp_held_flit", {21'b0, bus.data_out_0}, 32'h0C0);
    cyc(1);
    bus.ready_0 = 1'b1;
    expect_out(1'b0, 11'h0C0, "bp_header", w);
    chk("bp_header_gap", w, 1);
    expect_out(1'b0, 11'h011, "bp_body1", w);
    chk("bp_body1_gap", w, 1);
    expect_out(1'b0, 11'h012, "bp_body2", w);
    chk("bp_body2_gap", w, 1);
    expect_out(1'b0, 11'h013, "bp_body3", w);
    chk("bp_body3_gap", w, 1);
    expect_out(1'b0, 11'h414, "bp_tail", w);
    chk("bp_tail_gap", w, 1);
    cyc(1);

    // FIFO empty between flits; zero-hop-field body/tail stay on output 0
    push(11'h0C1);
    expect_out(1'b0, 11'h081, "gap_header", w);
    cyc(3);
    @(negedge clk);
    chk("gap_req_0_low", {31'b0, bus.req_0}, 0);
    cyc(1);
    push(11'h005);
    expect_out(1'b0, 11'h005, "gap_body_hop0", w);
    cyc(3);
    push(11'h400);
    expect_out(1'b0, 11'h400, "gap_tail_hop0", w);
    cyc(2);
    chk("gap_pkt_cnt_0", {16'b0, pkt_cnt_0}, 3);

    // Reset while a body flit is held
    bus.ready_0 = 1'b0;
    push(11'h0C2); push(11'h021);
    cyc(3);
    bus.ready_0 = 1'b1;
    cyc(1);
    bus.ready_0 = 1'b0;
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_req_0", {31'b0, bus.req_0}, 0);
    chk("mid_rst_req_1", {31'b0, bus.req_1}, 0);
    chk("mid_rst_pkt_cnt_0", {16'b0, pkt_cnt_0}, 0);
    chk("mid_rst_pkt_cnt_1", {16'b0, pkt_cnt_1}, 0);
    cyc(1);
    push(11'h42A);
    expect_out(1'b1, 11'h42A, "post_rst_local", w);
    cyc(1);

    // Counter wrap on output 0: single-flit packets, hop 1 -> 0
    bus.ready_0 = 1'b1;
    for (int i = 0; i < 65535; i++) push(11'h440);
    for (int i = 0; i < 70000 && rd_idx < src_q.size(); i++) cyc(1);
    chk("wrap_drain", {31'b0, (rd_idx >= src_q.size())}, 1);
    cyc(3);
    chk("wrap_pre_cnt_0", {16'b0, pkt_cnt_0}, 32'hFFFF);
    push(11'h440);
    cyc(5);
    chk("wrap_cnt_0", {16'b0, pkt_cnt_0}, 0);
    chk("wrap_cnt_1", {16'b0, pkt_cnt_1}, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
